// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and small helpers for the FIFO pointer/flag controller.
// Parameter defaults of the interface and the controller derive from here.
package fifo_ctrl_pkg;

    localparam int FIFO_DEPTH    = 16;
    localparam int FIFO_AW       = 4;
    localparam int FIFO_DW       = 8;
    localparam int FIFO_AF_LEVEL = 12;

    // Accepted operations in one cycle, encoded {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Push/pop handshake, status flags and memory-side signals of the FIFO controller.
// The slave modport is the controller; the master modport is the user plus memory.
interface fifo_ctrl_if
    import fifo_ctrl_pkg::*;
#(
    parameter int AW = FIFO_AW,
    parameter int DW = FIFO_DW
);
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          pop_req;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow_err;
    logic          underflow_err;
    logic          err_clr;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_waddr;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  flush, in_valid, in_data, pop_req, err_clr, mem_dout,
        output in_ready, out_valid, out_data, full, empty, almost_full, count,
               overflow_err, underflow_err, mem_we, mem_re, mem_waddr, mem_raddr, mem_din
    );

    modport master (
        output flush, in_valid, in_data, pop_req, err_clr, mem_dout,
        input  in_ready, out_valid, out_data, full, empty, almost_full, count,
               overflow_err, underflow_err, mem_we, mem_re, mem_waddr, mem_raddr, mem_din
    );

endinterface

// File: rtl/fifo_ctrl_wrap_ptr.sv
// AW-bit wrapping address pointer with synchronous clear and increment enable.
// Wrap from DEPTH-1 to 0 is the natural modulo-2^AW rollover.
module wrap_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int AW = FIFO_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] ptr_q, ptr_d;

    // Clear wins over increment so a flush cycle never advances the pointer.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i)      ptr_d = '0;
        else if (inc_i) ptr_d = ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: pointers, occupancy, flags, sticky errors and memory strobes
// in front of a synchronous-read memory. Holds no data; out_data is mem_dout.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int AW       = FIFO_AW,
    parameter int DW       = FIFO_DW,
    parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
    input  logic        clk,
    input  logic        rst,
    fifo_ctrl_if.slave  bus
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          full, empty;
    logic          push_ok, pop_ok;
    logic [AW-1:0] wr_ptr, rd_ptr;

    // Flags decode only from registered count, so in_ready has no path from pop_req.
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    assign push_ok = bus.in_valid && !full  && !bus.flush;
    assign pop_ok  = bus.pop_req  && !empty && !bus.flush;

    wrap_ptr #(.AW(AW)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.flush),
        .inc_i (push_ok),
        .ptr_o (wr_ptr)
    );

    wrap_ptr #(.AW(AW)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.flush),
        .inc_i (pop_ok),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = '0;
        end else begin
            unique case (fifo_op(push_ok, pop_ok))
                OP_PUSH: count_d = count_q + CNT_ONE;
                OP_POP:  count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Error set beats err_clr in the same cycle; flush leaves errors alone.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (bus.err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (bus.in_valid && full) ovf_d = 1'b1;
        if (bus.pop_req && empty) udf_d = 1'b1;
    end

    assign out_valid_d = pop_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign bus.in_ready      = !full;
    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.almost_full   = (count_q >= CNT_AF);
    assign bus.count         = count_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = bus.mem_dout;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = udf_q;

    assign bus.mem_we    = push_ok;
    assign bus.mem_re    = pop_ok;
    assign bus.mem_waddr = wr_ptr;
    assign bus.mem_raddr = rd_ptr;
    assign bus.mem_din   = bus.in_data;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed plus random bench for fifo_ctrl with a queue-based reference model
// and a behavioural 16x8 synchronous-read memory attached to the memory port.
module tb_fifo_ctrl;
    import fifo_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_ctrl_if #(.AW(FIFO_AW), .DW(FIFO_DW)) ifc ();

    fifo_ctrl #(
        .DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .DW(FIFO_DW), .AF_LEVEL(FIFO_AF_LEVEL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Attached memory: write and registered read on the same edge.
    logic [7:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (ifc.mem_re) ifc.mem_dout <= mem[ifc.mem_raddr];
        if (ifc.mem_we) mem[ifc.mem_waddr] <= ifc.mem_din;
    end

    // Reference model state
    logic [7:0] q[$];
    int         wcnt, rcnt;
    bit         m_ovf, m_udf, m_ov;
    logic [7:0] m_data;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wcnt = 0; rcnt = 0;
        m_ovf = 0; m_udf = 0; m_ov = 0;
    endtask

    task automatic chk_state();
        chk("count", 32'(ifc.count), 32'(q.size()));
        chk("empty", 32'(ifc.empty), 32'(q.size() == 0));
        chk("full", 32'(ifc.full), 32'(q.size() == 16));
        chk("almost_full", 32'(ifc.almost_full), 32'(q.size() >= 12));
        chk("in_ready", 32'(ifc.in_ready), 32'(q.size() != 16));
        chk("overflow_err", 32'(ifc.overflow_err), 32'(m_ovf));
        chk("underflow_err", 32'(ifc.underflow_err), 32'(m_udf));
        chk("out_valid", 32'(ifc.out_valid), 32'(m_ov));
        if (m_ov) chk("out_data", 32'(ifc.out_data), 32'(m_data));
    endtask

    task automatic step(input bit pv, input logic [7:0] pd, input bit pr,
                        input bit fl, input bit ec);
        bit push_ok, pop_ok;
        @(negedge clk);
        ifc.in_valid = pv; ifc.in_data = pd; ifc.pop_req = pr;
        ifc.flush = fl; ifc.err_clr = ec;
        #1;
        push_ok = pv && q.size() < 16 && !fl;
        pop_ok  = pr && q.size() > 0  && !fl;
        chk("mem_we", 32'(ifc.mem_we), 32'(push_ok));
        chk("mem_re", 32'(ifc.mem_re), 32'(pop_ok));
        if (push_ok) begin
            chk("mem_waddr", 32'(ifc.mem_waddr), 32'(wcnt % 16));
            chk("mem_din", 32'(ifc.mem_din), 32'(pd));
        end
        if (pop_ok) chk("mem_raddr", 32'(ifc.mem_raddr), 32'(rcnt % 16));
        @(posedge clk);
        if (ec) begin m_ovf = 0; m_udf = 0; end
        if (pv && q.size() == 16) m_ovf = 1;
        if (pr && q.size() == 0)  m_udf = 1;
        if (fl) begin
            q.delete(); wcnt = 0; rcnt = 0;
        end else begin
            if (pop_ok)  begin m_data = q.pop_front(); rcnt++; end
            if (push_ok) begin q.push_back(pd); wcnt++; end
        end
        m_ov = pop_ok;
        #1;
        chk_state();
    endtask

    task automatic push(input logic [7:0] d); step(1, d, 0, 0, 0); endtask
    task automatic pop();                     step(0, 8'h00, 1, 0, 0); endtask

    initial begin
        ifc.in_valid = 0; ifc.in_data = 0; ifc.pop_req = 0;
        ifc.flush = 0; ifc.err_clr = 0;
        model_reset();
        #12;
        chk_state();
        @(negedge clk) rst = 1'b1;
        #1;
        chk_state();
        chk("idle_mem_we", 32'(ifc.mem_we), 32'd0);
        chk("idle_mem_re", 32'(ifc.mem_re), 32'd0);
        step(0, 8'h00, 0, 0, 0);

        // Fill and drain in order
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        for (int i = 0; i < 16; i++) pop();
        step(0, 8'h00, 0, 0, 0);

        // Wrap-around of both pointers
        for (int i = 0; i < 10; i++) push(8'(i));
        for (int i = 0; i < 10; i++) pop();
        for (int i = 0; i < 10; i++) push(8'(8'hA0 + i));
        for (int i = 0; i < 10; i++) pop();

        // Simultaneous push/pop at empty, mid and full
        step(1, 8'h51, 1, 0, 0);
        for (int i = 0; i < 4; i++) push(8'(8'h52 + i));
        step(1, 8'h60, 1, 0, 0);
        for (int i = 0; i < 11; i++) push(8'(8'h70 + i));
        step(1, 8'h99, 1, 0, 0);

        // Sticky errors, held through flush, cleared by err_clr
        push(8'h7F);
        push(8'hEE);
        for (int i = 0; i < 16; i++) pop();
        pop();
        step(0, 8'h00, 0, 1, 0);
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'h01, 1, 0, 1);

        // Flush with a pop pending at count 7
        for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
        step(0, 8'h00, 1, 1, 0);
        step(0, 8'h00, 0, 0, 0);

        // Async reset between edges while a pop result is pending
        for (int i = 0; i < 3; i++) push(8'(8'hD0 + i));
        pop();
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_mem_raddr", 32'(ifc.mem_raddr), 32'd0);
        chk("rst_mem_waddr", 32'(ifc.mem_waddr), 32'd0);
        chk("rst_count", 32'(ifc.count), 32'd0);
        @(negedge clk);
        ifc.pop_req = 0;
        rst = 1'b1;
        step(0, 8'h00, 0, 0, 0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer, flag and handshake controller that turns the 16-entry x 8-bit synchronous-read memory into a true FIFO. Owns write/read pointers, occupancy count and full/empty/almost-full flags, and drives the memory's `we`, `re`, `w_addr`, `r_addr` and `din` from a valid/ready push side and a request/valid pop side. Sits directly in front of the memory instance. All data storage stays in the memory; this block holds no data registers.

## Interface
- `DEPTH`, 16: entries in the attached memory; power of two.
- `AW`, 4: address width, log2(DEPTH).
- `DW`, 8: data width.
- `AF_LEVEL`, 12: occupancy at or above which `almost_full` asserts; range 1..DEPTH.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of pointers, count and `out_valid`.
- `in_valid`  in  1  push request.
- `in_data`  in  DW  push data.
- `in_ready`  out  1  equals `!full`.
- `pop_req`  in  1  pop request.
- `out_valid`  out  1  `out_data` valid this cycle; one-cycle pulse per pop.
- `out_data`  out  DW  combinational pass-through of `mem_dout`.
- `full`, `empty`, `almost_full`  out  1 each  occupancy flags.
- `count`  out  AW+1  occupancy, 0..DEPTH.
- `overflow_err`, `underflow_err`  out  1 each  sticky error flags.
- `err_clr`  in  1  clears both error flags.
- `mem_we`, `mem_re`  out  1 each  memory write/read enables.
- `mem_waddr`, `mem_raddr`  out  AW each  memory addresses.
- `mem_din`  out  DW  memory write data, equals `in_data`.
- `mem_dout`  in  DW  memory registered read data.

## Operation
- Reset (`rst`=0, async): `wr_ptr`=0, `rd_ptr`=0, `count`=0, `out_valid`=0, both error flags 0. Hence `empty`=1, `full`=0, `almost_full`=0, `in_ready`=1. Memory contents are not cleared; flags gate all reads.
- Push accept: `in_valid && !full && !flush`. Drive `mem_we`=1, `mem_waddr`=`wr_ptr` (combinational). `wr_ptr` increments at the edge.
- Pop accept: `pop_req && !empty && !flush`. Drive `mem_re`=1, `mem_raddr`=`rd_ptr` (combinational). `rd_ptr` increments at the edge. `out_valid` is registered and set next cycle.
- Flags decode from the registered `count`: `full`=(count==DEPTH), `empty`=(count==0), `almost_full`=(count>=AF_LEVEL).
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers are AW bits and wrap DEPTH-1 -> 0 naturally.
- Simultaneous push and pop:
  - When full: pop proceeds, push is refused because `in_ready`=0 that cycle.
  - When empty: push proceeds, pop is refused.
  - Otherwise both proceed.
- `flush`: at the edge, sets pointers and `count` to 0 and `out_valid` to 0. Suppresses `mem_we`/`mem_re` that cycle. Does not touch error flags.
- Errors:
  - `overflow_err` sets on `in_valid && full`.
  - `underflow_err` sets on `pop_req && empty`.
  - Both hold until `err_clr` or reset. Set has priority over `err_clr` in the same cycle.
  - Error cycles do not change pointers or count.

## Timing
- Push-to-pop availability: a word accepted at edge N is poppable from cycle N+1 (`empty` falls after edge N). The memory write at edge N precedes the read at edge N+1, so there is no bypass and no hazard.
- Pop latency: pop accepted in cycle C -> `out_valid`=1 and `out_data` valid in cycle C+1. Back-to-back pops give back-to-back `out_valid`.
- Flags and `count` are registered: they change only at clock edges or async reset.
- `in_ready` is a function of the registered `full` only; no combinational path from `pop_req` to `in_ready`.
- Reset asserted mid-operation: all state clears immediately and asynchronously. A pending `out_valid` is dropped.

## Structure
- Shared package `fifo_ctrl_pkg`: constants `FIFO_DEPTH`=16, `FIFO_AW`=4, `FIFO_DW`=8, `FIFO_AF_LEVEL`=12; parameter defaults derive from these.
- One natural sub-module `wrap_ptr`: AW-bit pointer with async active-low reset, synchronous clear and increment enable. Instantiated twice (write and read).
- Count, flags, errors and `out_valid` live in `fifo_ctrl` itself.

## Test plan
- Reset then idle: after `rst` release, `empty`=1, `count`=0, `in_ready`=1, `mem_we`=`mem_re`=0.
- Fill/drain order:
  - Push 0x10..0x1F on 16 consecutive cycles: `full`=1 and `count`=16 after the 16th edge; `almost_full` asserts after the 12th.
  - Then pop 16 consecutive cycles: `out_data` is 0x10..0x1F in order, each one cycle after its pop; `empty`=1 at the end.
- Wrap-around: push 10, pop 10, then push 0xA0..0xA9. `mem_waddr` runs 10..15,0..3; popping returns 0xA0..0xA9 in order.
- Simultaneous push and pop:
  - At count=16 with both asserted: `count` goes to 15, write refused, `mem_we`=0.
  - At count=0 with both asserted: `count` goes to 1, `mem_re`=0.
  - At count=5 with both asserted: `count` stays 5.
- Errors: push at full -> `overflow_err`=1, `count` unchanged; pop at empty -> `underflow_err`=1. Both hold through `flush` and clear on `err_clr`.
- Flush and reset mid-stream:
  - At count=7, `flush` with a pop pending: next cycle `count`=0, `out_valid`=0, `mem_re`=0.
  - Async `rst` pulse between edges during a pop: `out_valid` drops immediately and pointers read 0.
